// File: rtl/k054000_pkg.sv
// Shared definitions for the K054000 collision-scan sequencer: FSM states,
// collision-chip register map and descriptor field layout.
package k054000_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetchA,
        StFetchB,
        StWrSetup,
        StWrStrobe,
        StRd,
        StRdSample,
        StNext,
        StDone
    } state_e;

    // Collision-chip register addresses (A[5:1])
    localparam logic [4:0] RegPosXA2   = 5'h01;
    localparam logic [4:0] RegPosXA1   = 5'h02;
    localparam logic [4:0] RegPosXA0   = 5'h03;
    localparam logic [4:0] RegExtXA    = 5'h04;
    localparam logic [4:0] RegMarginX  = 5'h06;
    localparam logic [4:0] RegMarginY  = 5'h07;
    localparam logic [4:0] RegPosYA2   = 5'h09;
    localparam logic [4:0] RegPosYA1   = 5'h0A;
    localparam logic [4:0] RegPosYA0   = 5'h0B;
    localparam logic [4:0] RegExtYA    = 5'h0C;
    localparam logic [4:0] RegExtXB    = 5'h0E;
    localparam logic [4:0] RegExtYB    = 5'h0F;
    localparam logic [4:0] RegPosYB2   = 5'h11;
    localparam logic [4:0] RegPosYB1   = 5'h12;
    localparam logic [4:0] RegPosYB0   = 5'h13;
    localparam logic [4:0] RegPosXB2   = 5'h15;
    localparam logic [4:0] RegPosXB1   = 5'h16;
    localparam logic [4:0] RegPosXB0   = 5'h17;
    localparam logic [4:0] RegReadback = 5'h18;

    // Descriptor field bit positions within the 64-bit RAM word
    localparam int unsigned PosXMsb = 63;
    localparam int unsigned PosXLsb = 40;
    localparam int unsigned PosYMsb = 39;
    localparam int unsigned PosYLsb = 16;
    localparam int unsigned ExtXMsb = 15;
    localparam int unsigned ExtXLsb = 8;
    localparam int unsigned ExtYMsb = 7;
    localparam int unsigned ExtYLsb = 0;

    // Write-sequence indices: 0..7 object i, 8..15 object j, 16..17 margins
    localparam logic [4:0] WrIdxObjB     = 5'd8;
    localparam logic [4:0] WrIdxObjBLast = 5'd15;
    localparam logic [4:0] WrIdxLast     = 5'd17;

    function automatic logic [4:0] wr_addr(input logic [4:0] idx);
        logic [4:0] a;
        case (idx)
            5'd0:    a = RegPosXA2;
            5'd1:    a = RegPosXA1;
            5'd2:    a = RegPosXA0;
            5'd3:    a = RegExtXA;
            5'd4:    a = RegPosYA2;
            5'd5:    a = RegPosYA1;
            5'd6:    a = RegPosYA0;
            5'd7:    a = RegExtYA;
            5'd8:    a = RegPosXB2;
            5'd9:    a = RegPosXB1;
            5'd10:   a = RegPosXB0;
            5'd11:   a = RegPosYB2;
            5'd12:   a = RegPosYB1;
            5'd13:   a = RegPosYB0;
            5'd14:   a = RegExtXB;
            5'd15:   a = RegExtYB;
            5'd16:   a = RegMarginX;
            5'd17:   a = RegMarginY;
            default: a = 5'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/k054000_buscyc.sv
// Two-cycle collision-chip bus-cycle generator. A held req runs one write
// (setup, strobe) or one read (address, sample) cycle and acks on the second.
module k054000_buscyc (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic       we_i,
    input  logic [4:0] addr_i,
    input  logic [7:0] data_i,
    output logic       ack_o,
    output logic       rbit_o,
    output logic [4:0] bus_a_o,
    output logic [7:0] bus_dout_o,
    output logic       bus_oe_o,
    output logic       bus_cs_o,
    output logic       bus_nwr_o,
    input  logic       bus_din0_i
);

    logic phase_q, phase_d;

    always_comb begin
        phase_d    = req_i & ~phase_q;
        ack_o      = req_i & phase_q;
        rbit_o     = bus_din0_i;
        bus_cs_o   = req_i;
        bus_oe_o   = req_i & we_i;
        // Strobe only in the second cycle so address/data have a full setup cycle
        bus_nwr_o  = ~(req_i & we_i & phase_q);
        bus_a_o    = req_i ? addr_i : 5'h00;
        bus_dout_o = (req_i & we_i) ? data_i : 8'h00;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/k054000_scanseq.sv
// Pairwise object collision scan driving a K054000-style collision chip.
// Define K054000_SCANSEQ_CACHE_EN to skip re-sending unchanged object-i state.
module k054000_scanseq
    import k054000_pkg::*;
#(
    parameter int unsigned MAX_OBJ = 16
) (
    input  logic               clk,
    input  logic               nRESET,
    input  logic               start,
    input  logic [4:0]         obj_count,
    input  logic [7:0]         margin_x,
    input  logic [7:0]         margin_y,
    output logic [3:0]         ram_addr,
    output logic               ram_rd,
    input  logic [63:0]        ram_q,
    output logic [4:0]         bus_a,
    output logic [7:0]         bus_dout,
    output logic               bus_oe,
    output logic               bus_cs,
    output logic               bus_nwr,
    input  logic               bus_din0,
    output logic               busy,
    output logic               done,
    output logic [MAX_OBJ-1:0] hit_flags
);

`ifdef K054000_SCANSEQ_CACHE_EN
    localparam bit CacheEn = 1'b1;
`else
    localparam bit CacheEn = 1'b0;
`endif

    localparam logic [4:0] MaxObj = 5'(MAX_OBJ);

    state_e             state_q, state_d;
    logic               fph_q, fph_d;
    logic [4:0]         i_q, i_d;
    logic [4:0]         j_q, j_d;
    logic [4:0]         n_q, n_d;
    logic [4:0]         wr_idx_q, wr_idx_d;
    logic               first_q, first_d;
    logic               newi_q, newi_d;
    logic [7:0]         mx_q, mx_d;
    logic [7:0]         my_q, my_d;
    logic [63:0]        desc_a_q, desc_a_d;
    logic [63:0]        desc_b_q, desc_b_d;
    logic [MAX_OBJ-1:0] hit_q, hit_d;

    logic       bus_req, bus_we, bus_ack, bus_rbit;
    logic [4:0] bus_addr;
    logic [7:0] bus_wdata, wr_data;
    logic [4:0] n_start;
    logic       wr_last;

    assign n_start = (obj_count > MaxObj) ? MaxObj : obj_count;

    // With caching, later pairs of the same i end after object j's eight writes
    assign wr_last = (wr_idx_q == WrIdxLast) ||
                     (CacheEn && !first_q && (wr_idx_q == WrIdxObjBLast));

    always_comb begin
        wr_data = 8'h00;
        case (wr_idx_q)
            5'd0:    wr_data = desc_a_q[PosXMsb -: 8];
            5'd1:    wr_data = desc_a_q[PosXMsb - 8 -: 8];
            5'd2:    wr_data = desc_a_q[PosXLsb +: 8];
            5'd3:    wr_data = desc_a_q[ExtXMsb:ExtXLsb];
            5'd4:    wr_data = desc_a_q[PosYMsb -: 8];
            5'd5:    wr_data = desc_a_q[PosYMsb - 8 -: 8];
            5'd6:    wr_data = desc_a_q[PosYLsb +: 8];
            5'd7:    wr_data = desc_a_q[ExtYMsb:ExtYLsb];
            5'd8:    wr_data = desc_b_q[PosXMsb -: 8];
            5'd9:    wr_data = desc_b_q[PosXMsb - 8 -: 8];
            5'd10:   wr_data = desc_b_q[PosXLsb +: 8];
            5'd11:   wr_data = desc_b_q[PosYMsb -: 8];
            5'd12:   wr_data = desc_b_q[PosYMsb - 8 -: 8];
            5'd13:   wr_data = desc_b_q[PosYLsb +: 8];
            5'd14:   wr_data = desc_b_q[ExtXMsb:ExtXLsb];
            5'd15:   wr_data = desc_b_q[ExtYMsb:ExtYLsb];
            5'd16:   wr_data = mx_q;
            5'd17:   wr_data = my_q;
            default: wr_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        fph_d     = fph_q;
        i_d       = i_q;
        j_d       = j_q;
        n_d       = n_q;
        wr_idx_d  = wr_idx_q;
        first_d   = first_q;
        newi_d    = newi_q;
        mx_d      = mx_q;
        my_d      = my_q;
        desc_a_d  = desc_a_q;
        desc_b_d  = desc_b_q;
        hit_d     = hit_q;
        ram_rd    = 1'b0;
        ram_addr  = 4'h0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 5'h00;
        bus_wdata = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    hit_d   = '0;
                    n_d     = n_start;
                    mx_d    = margin_x;
                    my_d    = margin_y;
                    i_d     = 5'd0;
                    j_d     = 5'd1;
                    first_d = 1'b1;
                    newi_d  = 1'b1;
                    fph_d   = 1'b0;
                    state_d = (n_start < 5'd2) ? StDone : StFetchA;
                end
            end
            StFetchA: begin
                ram_addr = i_q[3:0];
                ram_rd   = ~fph_q;
                fph_d    = ~fph_q;
                if (fph_q) begin
                    desc_a_d = ram_q;
                    state_d  = StFetchB;
                end
            end
            StFetchB: begin
                ram_addr = j_q[3:0];
                ram_rd   = ~fph_q;
                fph_d    = ~fph_q;
                if (fph_q) begin
                    desc_b_d = ram_q;
                    wr_idx_d = (CacheEn && !newi_q) ? WrIdxObjB : 5'd0;
                    state_d  = StWrSetup;
                end
            end
            StWrSetup: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = wr_addr(wr_idx_q);
                bus_wdata = wr_data;
                state_d   = StWrStrobe;
            end
            StWrStrobe: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = wr_addr(wr_idx_q);
                bus_wdata = wr_data;
                if (bus_ack) begin
                    if (wr_last) begin
                        state_d = StRd;
                    end else begin
                        wr_idx_d = wr_idx_q + 5'd1;
                        state_d  = StWrSetup;
                    end
                end
            end
            StRd: begin
                bus_req  = 1'b1;
                bus_addr = RegReadback;
                state_d  = StRdSample;
            end
            StRdSample: begin
                bus_req  = 1'b1;
                bus_addr = RegReadback;
                if (bus_ack) begin
                    if (bus_rbit) begin
                        for (int k = 0; k < MAX_OBJ; k++) begin
                            if ((5'(k) == i_q) || (5'(k) == j_q)) begin
                                hit_d[k] = 1'b1;
                            end
                        end
                    end
                    state_d = StNext;
                end
            end
            StNext: begin
                first_d = 1'b0;
                fph_d   = 1'b0;
                if (j_q == n_q - 5'd1) begin
                    if (i_q == n_q - 5'd2) begin
                        state_d = StDone;
                    end else begin
                        i_d     = i_q + 5'd1;
                        j_d     = i_q + 5'd2;
                        newi_d  = 1'b1;
                        state_d = StFetchA;
                    end
                end else begin
                    j_d     = j_q + 5'd1;
                    newi_d  = 1'b0;
                    state_d = CacheEn ? StFetchB : StFetchA;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= StIdle;
            fph_q    <= 1'b0;
            i_q      <= 5'd0;
            j_q      <= 5'd0;
            n_q      <= 5'd0;
            wr_idx_q <= 5'd0;
            first_q  <= 1'b0;
            newi_q   <= 1'b0;
            mx_q     <= 8'h00;
            my_q     <= 8'h00;
            desc_a_q <= 64'h0;
            desc_b_q <= 64'h0;
            hit_q    <= '0;
        end else begin
            state_q  <= state_d;
            fph_q    <= fph_d;
            i_q      <= i_d;
            j_q      <= j_d;
            n_q      <= n_d;
            wr_idx_q <= wr_idx_d;
            first_q  <= first_d;
            newi_q   <= newi_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            desc_a_q <= desc_a_d;
            desc_b_q <= desc_b_d;
            hit_q    <= hit_d;
        end
    end

    k054000_buscyc u_buscyc (
        .clk_i      (clk),
        .rst_ni     (nRESET),
        .req_i      (bus_req),
        .we_i       (bus_we),
        .addr_i     (bus_addr),
        .data_i     (bus_wdata),
        .ack_o      (bus_ack),
        .rbit_o     (bus_rbit),
        .bus_a_o    (bus_a),
        .bus_dout_o (bus_dout),
        .bus_oe_o   (bus_oe),
        .bus_cs_o   (bus_cs),
        .bus_nwr_o  (bus_nwr),
        .bus_din0_i (bus_din0)
    );

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign hit_flags = hit_q;

endmodule

// File: tb/tb_k054000_scanseq.sv
// Directed bench for k054000_scanseq with a descriptor RAM and a behavioural
// collision-chip register file answering the readback.
module tb_k054000_scanseq;

`ifdef K054000_SCANSEQ_CACHE_EN
    localparam bit Cache = 1'b1;
`else
    localparam bit Cache = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  obj_count = 5'd0;
    logic [7:0]  margin_x = 8'h00;
    logic [7:0]  margin_y = 8'h00;
    logic [3:0]  ram_addr;
    logic        ram_rd;
    logic [63:0] ram_q = 64'h0;
    logic [4:0]  bus_a;
    logic [7:0]  bus_dout;
    logic        bus_oe, bus_cs, bus_nwr, bus_din0;
    logic        busy, done;
    logic [15:0] hit_flags;

    k054000_scanseq #(.MAX_OBJ(16)) dut (
        .clk       (clk),
        .nRESET    (nRESET),
        .start     (start),
        .obj_count (obj_count),
        .margin_x  (margin_x),
        .margin_y  (margin_y),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_q     (ram_q),
        .bus_a     (bus_a),
        .bus_dout  (bus_dout),
        .bus_oe    (bus_oe),
        .bus_cs    (bus_cs),
        .bus_nwr   (bus_nwr),
        .bus_din0  (bus_din0),
        .busy      (busy),
        .done      (done),
        .hit_flags (hit_flags)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Descriptor RAM, one-cycle read latency
    logic [63:0] mem [16];
    always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

    function automatic logic [63:0] mk(input logic [23:0] px, input logic [23:0] py,
                                       input logic [7:0] ex, input logic [7:0] ey);
        return {px, py, ex, ey};
    endfunction

    // Collision chip: hit when |dx| <= extA+extB+mx and |dy| <= extA+extB+my
    logic [7:0]  regs [32];
    logic [23:0] pxa, pxb, pya, pyb, dx, dy;
    logic [25:0] limx, limy;
    logic        chip_hit;
    always_comb begin
        pxa  = {regs[5'h01], regs[5'h02], regs[5'h03]};
        pya  = {regs[5'h09], regs[5'h0A], regs[5'h0B]};
        pxb  = {regs[5'h15], regs[5'h16], regs[5'h17]};
        pyb  = {regs[5'h11], regs[5'h12], regs[5'h13]};
        dx   = (pxa > pxb) ? pxa - pxb : pxb - pxa;
        dy   = (pya > pyb) ? pya - pyb : pyb - pya;
        limx = 26'(regs[5'h04]) + 26'(regs[5'h0E]) + 26'(regs[5'h06]);
        limy = 26'(regs[5'h0C]) + 26'(regs[5'h0F]) + 26'(regs[5'h07]);
        chip_hit = ({2'b00, dx} <= limx) && ({2'b00, dy} <= limy);
    end
    assign bus_din0 = chip_hit;

    // Bus monitor: counts activity and checks setup/strobe protocol
    int wr_cnt = 0, rd_cyc = 0, cs_cnt = 0, rds_cnt = 0, mon_err = 0;
    logic prev_cs = 1'b0, prev_nwr = 1'b1;
    logic [4:0] prev_a = 5'h0;
    logic [7:0] prev_d = 8'h0;
    always @(negedge clk) begin
        if (bus_cs) cs_cnt++;
        if (ram_rd) rds_cnt++;
        if (bus_cs && !bus_nwr) begin
            wr_cnt++;
            if (!prev_cs || !prev_nwr || prev_a != bus_a || prev_d != bus_dout || !bus_oe)
                mon_err++;
            regs[bus_a] = bus_dout;
        end
        if (bus_cs && !bus_oe) begin
            rd_cyc++;
            if (bus_a != 5'h18 || !bus_nwr) mon_err++;
        end
        if (!bus_cs && (bus_oe || !bus_nwr)) mon_err++;
        prev_cs  = bus_cs;
        prev_nwr = bus_nwr;
        prev_a   = bus_a;
        prev_d   = bus_dout;
    end

    function automatic int pairs_of(input int n);
        return (n < 2) ? 0 : n * (n - 1) / 2;
    endfunction

    function automatic int exp_lat(input int n);
        if (n < 2) return 1;
        if (!Cache) return pairs_of(n) * 43 + 1;
        return 43 + 39 * (n - 2) + 21 * (pairs_of(n) - (n - 1)) + 1;
    endfunction

    function automatic int exp_wr(input int n);
        if (n < 2) return 0;
        if (!Cache) return 18 * pairs_of(n);
        return 18 + 16 * (n - 2) + 8 * (pairs_of(n) - (n - 1));
    endfunction

    function automatic int exp_rds(input int n);
        if (n < 2) return 0;
        if (!Cache) return 2 * pairs_of(n);
        return pairs_of(n) + (n - 1);
    endfunction

    task automatic run_scan(input string pfx, input int cnt, input logic [7:0] mx,
                            input logic [7:0] my, input bit repulse, input int n_eff,
                            input int exp_hits, input int exp_rb);
        int cyc, busy_gap, w0, r0, c0, s0;
        @(negedge clk);
        obj_count = 5'(cnt);
        margin_x  = mx;
        margin_y  = my;
        start     = 1'b1;
        w0 = wr_cnt; r0 = rd_cyc; c0 = cs_cnt; s0 = rds_cnt;
        @(posedge clk);
        cyc = 0;
        busy_gap = 0;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == 3) begin
                margin_x = 8'h00;
                margin_y = 8'h00;
            end
            if (repulse && cyc == 10) begin
                start     = 1'b1;
                obj_count = 5'd3;
            end
            if (repulse && cyc == 11) start = 1'b0;
            if (!busy) busy_gap++;
            if (done) break;
        end
        check({pfx, "_latency"}, cyc, exp_lat(n_eff));
        check({pfx, "_hits"}, int'(hit_flags), exp_hits);
        check({pfx, "_busy_gap"}, busy_gap, 0);
        check({pfx, "_writes"}, wr_cnt - w0, exp_wr(n_eff));
        check({pfx, "_readbacks"}, (rd_cyc - r0) / 2, exp_rb);
        check({pfx, "_cs_cycles"}, cs_cnt - c0, 2 * exp_wr(n_eff) + 2 * exp_rb);
        check({pfx, "_ram_reads"}, rds_cnt - s0, exp_rds(n_eff));
        @(negedge clk);
        check({pfx, "_done_pulse"}, int'({done, busy}), 0);
        check({pfx, "_hits_hold"}, int'(hit_flags), exp_hits);
    endtask

    initial begin
        bit found;
        int w0;
        for (int k = 0; k < 32; k++) regs[k] = 8'h00;
        for (int k = 0; k < 16; k++) mem[k] = 64'h0;

        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bus", int'({bus_cs, bus_oe, bus_nwr, ram_rd}), 4'b0010);
        check("rst_addr", int'({bus_a, bus_dout, ram_addr}), 0);
        check("rst_hits", int'(hit_flags), 0);
        nRESET = 1'b1;
        repeat (2) @(negedge clk);

        // Two overlapping objects
        mem[0] = mk(24'h000100, 24'h000200, 8'h10, 8'h10);
        mem[1] = mk(24'h000104, 24'h000200, 8'h10, 8'h10);
        run_scan("n2", 2, 8'h00, 8'h00, 1'b0, 2, 16'h0003, 1);

        // Object 0 overlaps in X only; 1 and 2 overlap
        mem[0] = mk(24'h000100, 24'h015000, 8'h10, 8'h10);
        mem[1] = mk(24'h000108, 24'h000200, 8'h10, 8'h10);
        mem[2] = mk(24'h000110, 24'h000208, 8'h10, 8'h10);
        run_scan("n3", 3, 8'h00, 8'h00, 1'b0, 3, 16'h0006, 3);

        // Degenerate counts: flags from the previous scan must clear
        run_scan("n1", 1, 8'h00, 8'h00, 1'b0, 1, 16'h0000, 0);
        run_scan("n0", 0, 8'h00, 8'h00, 1'b0, 0, 16'h0000, 0);

        // Reset in the middle of a write strobe
        mem[0] = mk(24'h000100, 24'h000200, 8'h10, 8'h10);
        mem[1] = mk(24'h000104, 24'h000200, 8'h10, 8'h10);
        @(negedge clk);
        obj_count = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus_cs && !bus_nwr) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_mid_found_strobe", int'(found), 1);
        #2 nRESET = 1'b0;
        #1;
        check("rst_mid_nwr", int'(bus_nwr), 1);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_bus", int'({bus_cs, bus_oe, ram_rd, done}), 0);
        check("rst_mid_addr", int'({bus_a, bus_dout, ram_addr}), 0);
        check("rst_mid_hits", int'(hit_flags), 0);
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        nRESET = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_no_resume_writes", wr_cnt - w0, 0);
        check("rst_no_resume_busy", int'(busy), 0);

        // Sixteen objects via clamped count; 5/6 touch exactly, 14/15 only via margin
        for (int k = 0; k < 16; k++) mem[k] = mk(24'(k * 256), 24'h001000, 8'h10, 8'h10);
        mem[6]  = mk(24'h000520, 24'h001000, 8'h10, 8'h10);
        mem[15] = mk(24'h000E30, 24'h001000, 8'h10, 8'h10);
        run_scan("n20", 20, 8'h10, 8'h22, 1'b1, 16, 16'hC060, 120);

        // Four objects: cached object i must give the same flags
        mem[0] = mk(24'h010000, 24'h000300, 8'h10, 8'h10);
        mem[1] = mk(24'h010010, 24'h000300, 8'h10, 8'h10);
        mem[2] = mk(24'h020000, 24'h000300, 8'h10, 8'h10);
        mem[3] = mk(24'h010020, 24'h000310, 8'h10, 8'h10);
        run_scan("n4", 4, 8'h00, 8'h00, 1'b0, 4, 16'h000B, 6);

        check("bus_protocol", mon_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
